// File: rtl/sram_rr_port_arbiter_if.sv
// Bundle of requester-side handshakes and SRAM-wrapper signals for sram_rr_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters-plus-SRAM view.
interface sram_rr_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            wr_valid;
    logic [NUM_REQ-1:0]            wr_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] wr_adr;
    logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]            rd_valid;
    logic [NUM_REQ-1:0]            rd_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] rd_adr;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          mem_wen;
    logic [ADDR_WIDTH-1:0]         mem_wadr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic                          mem_ren;
    logic [ADDR_WIDTH-1:0]         mem_radr;
    logic [DATA_WIDTH-1:0]         mem_rdata;

    modport slave (
        input  wr_valid, wr_adr, wr_data, rd_valid, rd_adr, mem_rdata,
        output wr_ready, rd_ready, rsp_valid, rsp_data,
               mem_wen, mem_wadr, mem_wdata, mem_ren, mem_radr
    );

    modport master (
        output wr_valid, wr_adr, wr_data, rd_valid, rd_adr, mem_rdata,
        input  wr_ready, rd_ready, rsp_valid, rsp_data,
               mem_wen, mem_wadr, mem_wdata, mem_ren, mem_radr
    );
endinterface

// File: rtl/sram_rr_port_arbiter.sv
// Round-robin sharing of a 1RW1R sync SRAM among NUM_REQ requesters, tagged read responses.
// Define SRAM_ARB_FWD_EN to forward same-cycle write data to a colliding read instead of stalling it.
module sram_rr_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 1
) (
    input logic                   clk,
    input logic                   reset,
    sram_rr_port_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] wr_adr_a, rd_adr_a;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data_a;

    assign wr_adr_a  = bus.wr_adr;
    assign rd_adr_a  = bus.rd_adr;
    assign wr_data_a = bus.wr_data;

    // Returns {found, index} of the first request at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [PW-1:0]      ptr);
        logic [PW:0] r;
        int          c;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % NUM_REQ;
            if (req[PW'(c)]) r = {1'b1, PW'(c)};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] idx);
        return (idx == PW'(NUM_REQ - 1)) ? '0 : idx + PW'(1);
    endfunction

    logic [PW-1:0] wr_ptr, rd_ptr, wr_idx, rd_idx;
    logic          wr_found, rd_found;
    logic          wr_go, rd_go, hazard;
    logic [NUM_REQ-1:0] wr_gnt, rd_gnt;

    assign {wr_found, wr_idx} = rr_pick(bus.wr_valid, wr_ptr);
    assign {rd_found, rd_idx} = rr_pick(bus.rd_valid, rd_ptr);

    assign wr_go  = wr_found && !reset;
    assign hazard = wr_go && rd_found && (wr_adr_a[wr_idx] == rd_adr_a[rd_idx]);
`ifdef SRAM_ARB_FWD_EN
    assign rd_go  = rd_found && !reset;
`else
    assign rd_go  = rd_found && !reset && !hazard;
`endif

    assign wr_gnt = wr_go ? (NUM_REQ'(1) << wr_idx) : '0;
    assign rd_gnt = rd_go ? (NUM_REQ'(1) << rd_idx) : '0;

    assign bus.wr_ready  = wr_gnt;
    assign bus.rd_ready  = rd_gnt;
    assign bus.mem_wen   = wr_go;
    assign bus.mem_wadr  = wr_adr_a[wr_idx];
    assign bus.mem_wdata = wr_data_a[wr_idx];
    assign bus.mem_ren   = rd_go;
    assign bus.mem_radr  = rd_adr_a[rd_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_go) wr_ptr <= ptr_next(wr_idx);
            if (rd_go) rd_ptr <= ptr_next(rd_idx);
        end
    end

    // Response pipe tracks the SRAM read latency; stage RD_LATENCY-1 lines up with mem_rdata.
    logic [RD_LATENCY-1:0]                 vld_pipe;
    logic [RD_LATENCY-1:0][NUM_REQ-1:0]    tag_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_go;
            tag_pipe[0] <= rd_gnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign bus.rsp_valid = (vld_pipe[RD_LATENCY-1] && !reset) ? tag_pipe[RD_LATENCY-1] : '0;

`ifdef SRAM_ARB_FWD_EN
    logic [RD_LATENCY-1:0]                 fwd_pipe;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] fwd_data_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_pipe      <= '0;
            fwd_data_pipe <= '0;
        end else begin
            fwd_pipe[0]      <= hazard;
            fwd_data_pipe[0] <= wr_data_a[wr_idx];
            for (int i = 1; i < RD_LATENCY; i++) begin
                fwd_pipe[i]      <= fwd_pipe[i-1];
                fwd_data_pipe[i] <= fwd_data_pipe[i-1];
            end
        end
    end

    assign bus.rsp_data = !(|bus.rsp_valid)       ? '0 :
                          fwd_pipe[RD_LATENCY-1] ? fwd_data_pipe[RD_LATENCY-1] : bus.mem_rdata;
`else
    assign bus.rsp_data = (|bus.rsp_valid) ? bus.mem_rdata : '0;
`endif
endmodule

// File: tb/tb_sram_rr_port_arbiter.sv
// Directed bench for sram_rr_port_arbiter with a behavioural sync SRAM (read-before-write) attached.
module tb_sram_rr_port_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NR  = 2;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_rr_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    sram_rr_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .RD_LATENCY(LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // SRAM model: read samples the array before the same-edge write lands.
    logic [DW-1:0]          mem [0:255];
    logic [LAT-1:0][DW-1:0] rd_q = '0;

    always_ff @(posedge clk) begin
        rd_q[0] <= bus.mem_ren ? mem[bus.mem_radr] : '0;
        for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
        if (bus.mem_wen) mem[bus.mem_wadr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = rd_q[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.wr_valid = '0;
        bus.rd_valid = '0;
        bus.wr_adr   = '0;
        bus.wr_data  = '0;
        bus.rd_adr   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] e_tag, e_dat;
        reset = 1'b1;
        idle();

        // Reset held with every valid high: nothing may be granted.
        bus.wr_valid = '1;
        bus.rd_valid = '1;
        bus.wr_adr   = {8'h05, 8'h06};
        bus.rd_adr   = {8'h07, 8'h08};
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            chk("rst_wr_ready", 64'(bus.wr_ready), 64'h0);
            chk("rst_rd_ready", 64'(bus.rd_ready), 64'h0);
            chk("rst_mem_wen",  64'(bus.mem_wen),  64'h0);
            chk("rst_mem_ren",  64'(bus.mem_ren),  64'h0);
            chk("rst_rsp",      64'(bus.rsp_valid), 64'h0);
        end
        reset = 1'b0;
        idle();
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            chk("idle_rsp", 64'(bus.rsp_valid), 64'h0);
            chk("idle_wen", 64'(bus.mem_wen),   64'h0);
            chk("idle_ren", 64'(bus.mem_ren),   64'h0);
        end

        // Write then read back through requester 0.
        tick();
        bus.wr_valid = 2'b01; bus.wr_adr[AW-1:0] = 8'h10; bus.wr_data[DW-1:0] = 32'hDEADBEEF;
        #1;
        chk("w0_ready", 64'(bus.wr_ready),  64'h1);
        chk("w0_wen",   64'(bus.mem_wen),   64'h1);
        chk("w0_wadr",  64'(bus.mem_wadr),  64'h10);
        chk("w0_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
        tick();
        bus.wr_valid = 2'b00; bus.rd_valid = 2'b01; bus.rd_adr[AW-1:0] = 8'h10;
        #1;
        chk("r0_ready", 64'(bus.rd_ready), 64'h1);
        chk("r0_ren",   64'(bus.mem_ren),  64'h1);
        chk("r0_radr",  64'(bus.mem_radr), 64'h10);
        tick(); bus.rd_valid = 2'b00; #1;
        chk("r0_early", 64'(bus.rsp_valid), 64'h0);
        tick(); #1;
        chk("r0_rsp",   64'(bus.rsp_valid), 64'h1);
        chk("r0_data",  64'(bus.rsp_data),  64'hDEADBEEF);
        tick(); #1;
        chk("r0_once",  64'(bus.rsp_valid), 64'h0);

        // Both writers valid; write pointer now sits at 1 so requester 1 wins.
        tick();
        bus.wr_valid = 2'b11;
        bus.wr_adr   = {8'h11, 8'h30};
        bus.wr_data  = {32'h11112222, 32'h33334444};
        #1;
        chk("w1_ready", 64'(bus.wr_ready), 64'h2);
        chk("w1_wadr",  64'(bus.mem_wadr), 64'h11);
        tick(); idle(); reset = 1'b1;
        tick(); reset = 1'b0;

        // Fairness: both readers held for 6 cycles.
        for (int c = 0; c < 8; c++) begin
            tick();
            bus.rd_valid = (c < 6) ? 2'b11 : 2'b00;
            bus.rd_adr   = {8'h11, 8'h10};
            #1;
            if (c < 6) chk("fair_ready", 64'(bus.rd_ready), (c % 2 == 0) ? 64'h1 : 64'h2);
            e_tag = (c < 2) ? 64'h0 : (((c - 2) % 2 == 0) ? 64'h1 : 64'h2);
            e_dat = (e_tag == 64'h1) ? 64'hDEADBEEF : (e_tag == 64'h2) ? 64'h11112222 : 64'h0;
            chk("fair_tag",  64'(bus.rsp_valid), e_tag);
            chk("fair_data", 64'(bus.rsp_data),  e_dat);
        end

        // Sparse: req1 alone three times, then both -> req0.
        for (int c = 0; c < 6; c++) begin
            tick();
            bus.rd_valid = (c < 3) ? 2'b10 : (c == 3) ? 2'b11 : 2'b00;
            #1;
            chk("sparse_ready", 64'(bus.rd_ready), (c < 3) ? 64'h2 : (c == 3) ? 64'h1 : 64'h0);
            e_tag = (c < 2) ? 64'h0 : ((c - 2) < 3) ? 64'h2 : 64'h1;
            e_dat = (e_tag == 64'h1) ? 64'hDEADBEEF : (e_tag == 64'h2) ? 64'h11112222 : 64'h0;
            chk("sparse_tag",  64'(bus.rsp_valid), e_tag);
            chk("sparse_data", 64'(bus.rsp_data),  e_dat);
        end

        // Hazard: 0x20 holds 1, then write 2 and read 0x20 in the same cycle.
        tick(); idle();
        bus.wr_valid = 2'b01; bus.wr_adr[AW-1:0] = 8'h20; bus.wr_data[DW-1:0] = 32'h1;
        #1;
        chk("hz_pre_ready", 64'(bus.wr_ready), 64'h1);
        tick();
        bus.wr_valid = 2'b10; bus.wr_adr[2*AW-1:AW] = 8'h20; bus.wr_data[2*DW-1:DW] = 32'h2;
        bus.rd_valid = 2'b01; bus.rd_adr[AW-1:0] = 8'h20;
        #1;
        chk("hz_wr_ready", 64'(bus.wr_ready), 64'h2);
        chk("hz_wen",      64'(bus.mem_wen),  64'h1);
`ifdef SRAM_ARB_FWD_EN
        chk("hz_rd_ready", 64'(bus.rd_ready), 64'h1);
        tick(); bus.wr_valid = 2'b00; bus.rd_valid = 2'b00; #1;
        chk("hz_early", 64'(bus.rsp_valid), 64'h0);
`else
        chk("hz_rd_stall", 64'(bus.rd_ready), 64'h0);
        chk("hz_ren_stall", 64'(bus.mem_ren), 64'h0);
        tick(); bus.wr_valid = 2'b00; #1;
        chk("hz_retry_ready", 64'(bus.rd_ready), 64'h1);
        chk("hz_retry_ren",   64'(bus.mem_ren),  64'h1);
        tick(); bus.rd_valid = 2'b00; #1;
        chk("hz_early", 64'(bus.rsp_valid), 64'h0);
`endif
        tick(); #1;
        chk("hz_tag",  64'(bus.rsp_valid), 64'h1);
        chk("hz_data", 64'(bus.rsp_data),  64'h2);
        tick(); #1;
        chk("hz_once", 64'(bus.rsp_valid), 64'h0);

        // Reset one cycle after a read handshake drops that response.
        tick(); idle();
        bus.rd_valid = 2'b01; bus.rd_adr = {8'h11, 8'h10};
        #1;
        chk("rr_ready", 64'(bus.rd_ready), 64'h1);
        tick(); bus.rd_valid = 2'b10; reset = 1'b1; #1;
        chk("rr_rst_ready", 64'(bus.rd_ready), 64'h0);
        chk("rr_rst_ren",   64'(bus.mem_ren),  64'h0);
        chk("rr_rst_rsp",   64'(bus.rsp_valid), 64'h0);
        tick(); bus.rd_valid = 2'b00; reset = 1'b0; #1;
        chk("rr_dropped", 64'(bus.rsp_valid), 64'h0);
        tick(); bus.rd_valid = 2'b11; #1;
        chk("rr_post_ready", 64'(bus.rd_ready), 64'h1);
        chk("rr_post_none",  64'(bus.rsp_valid), 64'h0);
        tick(); bus.rd_valid = 2'b00; #1;
        chk("rr_post_early", 64'(bus.rsp_valid), 64'h0);
        tick(); #1;
        chk("rr_post_tag",  64'(bus.rsp_valid), 64'h1);
        chk("rr_post_data", 64'(bus.rsp_data),  64'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
